// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load writebacks onto one register-bank write port
// and tracks pending destination registers in a scoreboard for decode stall detection.
module wb_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        hazard,
    output logic [4:0]  writePort,
    output logic [31:0] busC,
    output logic        regWrite
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e      r_last_grant;
    logic        r_reg_write;
    logic [4:0]  r_write_port;
    logic [31:0] r_bus_c;
    logic [31:0] r_busy;

    logic        w_alu_grant;
    logic        w_mem_grant;
    logic        w_xfer;
    logic [4:0]  w_xfer_rd;
    logic [31:0] w_xfer_data;
    logic        w_write_en;
    logic [31:0] w_clr_mask;
    logic [31:0] w_set_mask;
    logic [31:0] w_busy_vis;

    always_comb begin
        w_alu_grant = 1'b0;
        w_mem_grant = 1'b0;
        if (!rst) begin
            if (alu_valid && mem_valid) begin
                if (FIXED_PRIO != 0 || r_last_grant == GRANT_ALU) begin
                    w_mem_grant = 1'b1;
                end else begin
                    w_alu_grant = 1'b1;
                end
            end else begin
                w_alu_grant = alu_valid;
                w_mem_grant = mem_valid;
            end
        end
    end

    assign alu_ready   = w_alu_grant;
    assign mem_ready   = w_mem_grant;
    assign w_xfer      = w_alu_grant | w_mem_grant;
    assign w_xfer_rd   = w_mem_grant ? mem_rd : alu_rd;
    assign w_xfer_data = w_mem_grant ? mem_data : alu_data;

    // The registered write is masked by rst so nothing reaches the bank once reset asserts.
    assign w_write_en = r_reg_write & ~rst;
    assign regWrite   = w_write_en;
    assign writePort  = r_write_port;
    assign busC       = r_bus_c;

    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (w_write_en) begin
            w_clr_mask[r_write_port] = 1'b1;
        end
        if (issue_valid && issue_rd != 5'd0) begin
            w_set_mask[issue_rd] = 1'b1;
        end
    end

    // The register being written this cycle is already forwarded, so it no longer stalls.
    assign w_busy_vis = r_busy & ~w_clr_mask;

    always_comb begin
        hazard = 1'b0;
        if (!rst) begin
            hazard = (rs1 != 5'd0 && w_busy_vis[rs1]) ||
                     (rs2 != 5'd0 && w_busy_vis[rs2]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GRANT_ALU;
            r_reg_write  <= 1'b0;
            r_write_port <= '0;
            r_bus_c      <= '0;
            r_busy       <= '0;
        end else begin
            r_reg_write <= w_xfer && (w_xfer_rd != 5'd0);
            if (w_xfer) begin
                r_write_port <= w_xfer_rd;
                r_bus_c      <= w_xfer_data;
                r_last_grant <= w_mem_grant ? GRANT_MEM : GRANT_ALU;
            end
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter: round-robin and fixed-priority instances share reset,
// issue and decode inputs, each with its own requesters, checked against a behavioural model.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    logic        alu_valid [2];
    logic [4:0]  alu_rd    [2];
    logic [31:0] alu_data  [2];
    logic        alu_ready [2];
    logic        mem_valid [2];
    logic [4:0]  mem_rd    [2];
    logic [31:0] mem_data  [2];
    logic        mem_ready [2];
    logic        hazard    [2];
    logic [4:0]  writePort [2];
    logic [31:0] busC      [2];
    logic        regWrite  [2];

    int n_checks;
    int n_errors;

    wb_arbiter #(.FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid[0]), .alu_rd(alu_rd[0]), .alu_data(alu_data[0]), .alu_ready(alu_ready[0]),
        .mem_valid(mem_valid[0]), .mem_rd(mem_rd[0]), .mem_data(mem_data[0]), .mem_ready(mem_ready[0]),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .hazard(hazard[0]), .writePort(writePort[0]), .busC(busC[0]), .regWrite(regWrite[0])
    );

    wb_arbiter #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid[1]), .alu_rd(alu_rd[1]), .alu_data(alu_data[1]), .alu_ready(alu_ready[1]),
        .mem_valid(mem_valid[1]), .mem_rd(mem_rd[1]), .mem_data(mem_data[1]), .mem_ready(mem_ready[1]),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .hazard(hazard[1]), .writePort(writePort[1]), .busC(busC[1]), .regWrite(regWrite[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int inst, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s inst=%0d t=%0t got=%h exp=%h", tag, inst, $time, got, exp);
        end
    endtask

    // Reference model state, one slot per instance (0 = round-robin, 1 = fixed priority).
    bit        m_last_mem [2];
    bit [31:0] m_busy     [2];
    bit        m_rw       [2];
    bit [4:0]  m_wp       [2];
    bit [31:0] m_bc       [2];
    bit        m_known    [2];
    bit        m_wp_known [2];
    bit        a_taken    [2];
    bit        m_taken    [2];

    bit        g_a, g_m, eff_rw, exp_haz;
    bit [4:0]  x_rd;
    bit [31:0] x_data;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1         = '0;
        rs2         = '0;
        for (int k = 0; k < 2; k++) begin
            alu_valid[k] = 1'b0; alu_rd[k] = '0; alu_data[k] = '0;
            mem_valid[k] = 1'b0; mem_rd[k] = '0; mem_data[k] = '0;
            m_known[k] = 1'b0; a_taken[k] = 1'b0; m_taken[k] = 1'b0;
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst         = (cyc < 2) || ($urandom_range(0, 59) == 0);
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 7));
            for (int k = 0; k < 2; k++) begin
                if (a_taken[k]) begin alu_valid[k] = 1'b0; a_taken[k] = 1'b0; end
                if (m_taken[k]) begin mem_valid[k] = 1'b0; m_taken[k] = 1'b0; end
                if (!alu_valid[k] && $urandom_range(0, 2) != 0) begin
                    alu_valid[k] = 1'b1;
                    alu_rd[k]    = 5'($urandom_range(0, 7));
                    alu_data[k]  = $urandom;
                end
                if (!mem_valid[k] && $urandom_range(0, 2) != 0) begin
                    mem_valid[k] = 1'b1;
                    mem_rd[k]    = 5'($urandom_range(0, 7));
                    mem_data[k]  = $urandom;
                end
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                g_a = 1'b0;
                g_m = 1'b0;
                if (!rst) begin
                    if (alu_valid[k] && mem_valid[k]) begin
                        if (k == 1 || !m_last_mem[k]) g_m = 1'b1;
                        else                          g_a = 1'b1;
                    end else begin
                        g_a = alu_valid[k];
                        g_m = mem_valid[k];
                    end
                end
                eff_rw  = m_rw[k] && !rst;
                exp_haz = 1'b0;
                if (!rst) begin
                    if (rs1 != 0 && m_busy[k][rs1] && !(eff_rw && rs1 == m_wp[k])) exp_haz = 1'b1;
                    if (rs2 != 0 && m_busy[k][rs2] && !(eff_rw && rs2 == m_wp[k])) exp_haz = 1'b1;
                end

                check_eq("alu_ready", k, 32'(alu_ready[k]), 32'(g_a));
                check_eq("mem_ready", k, 32'(mem_ready[k]), 32'(g_m));
                check_eq("hazard",    k, 32'(hazard[k]),    32'(exp_haz));
                check_eq("regWrite",  k, 32'(regWrite[k]),  32'(eff_rw));
                if (m_known[k] && (eff_rw || m_wp_known[k])) begin
                    check_eq("writePort", k, 32'(writePort[k]), 32'(m_wp[k]));
                    check_eq("busC",      k, busC[k],           m_bc[k]);
                end

                if (rst) begin
                    m_busy[k] = '0; m_rw[k] = 1'b0; m_wp[k] = '0; m_bc[k] = '0;
                    m_last_mem[k] = 1'b0; m_known[k] = 1'b1; m_wp_known[k] = 1'b1;
                end else begin
                    if (eff_rw) m_busy[k][m_wp[k]] = 1'b0;
                    if (issue_valid && issue_rd != 0) m_busy[k][issue_rd] = 1'b1;
                    if (g_a || g_m) begin
                        x_rd   = g_m ? mem_rd[k] : alu_rd[k];
                        x_data = g_m ? mem_data[k] : alu_data[k];
                        m_rw[k] = (x_rd != 0);
                        if (x_rd != 0) begin
                            m_wp[k] = x_rd; m_bc[k] = x_data; m_wp_known[k] = 1'b1;
                        end else begin
                            m_wp_known[k] = 1'b0;
                        end
                        m_last_mem[k] = g_m;
                        if (g_m) m_taken[k] = 1'b1;
                        else     a_taken[k] = 1'b1;
                    end else begin
                        m_rw[k] = 1'b0;
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin arbitration, 1 = mem requester always wins conflicts.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port alu_valid  input  1  ALU writeback request.
REQ-005 The block SHALL have port alu_rd  input  5  ALU destination register index.
REQ-006 The block SHALL have port alu_data  input  32  ALU result.
REQ-007 The block SHALL have port alu_ready  output  1  ALU request accepted this cycle (combinational).
REQ-008 The block SHALL have ports mem_valid/mem_rd/mem_data/mem_ready with the same widths and meaning for load writeback.
REQ-009 The block SHALL have port issue_valid  input  1  an instruction with a destination register issues this cycle.
REQ-010 The block SHALL have port issue_rd  input  5  destination index of the issuing instruction.
REQ-011 The block SHALL have ports rs1, rs2  input  5 each  source indices of the instruction in decode.
REQ-012 The block SHALL have port hazard  output  1  decode must stall (combinational).
REQ-013 The block SHALL have ports writePort  output  5, busC  output  32, regWrite  output  1, driving the register bank write port, all registered.

Function
REQ-014 A transfer SHALL occur when x_valid && x_ready in the same cycle; requesters hold valid/rd/data stable until ready.
REQ-015 x_ready SHALL be asserted only when x_valid is high and x wins arbitration; at most one ready per cycle.
REQ-016 Only one requester valid: it SHALL be granted that cycle.
REQ-017 Both valid with FIXED_PRIO=1: mem SHALL be granted; alu waits.
REQ-018 Both valid with FIXED_PRIO=0: grant SHALL go to the requester not recorded in last_grant; last_grant updates on every transfer to the granted requester.
REQ-019 A transfer in cycle N SHALL produce regWrite=1, writePort=rd, busC=data in cycle N+1 for exactly one cycle; throughput one write per cycle.
REQ-020 A transfer with rd=0 SHALL complete the handshake but produce regWrite=0 in cycle N+1 and clear no scoreboard bit.
REQ-021 No transfer in cycle N: regWrite SHALL be 0 in N+1; writePort and busC hold their previous values.
REQ-022 Scoreboard busy[31:1] SHALL set bit issue_rd on issue_valid with issue_rd!=0; busy[0] is constant 0.
REQ-023 A cycle with regWrite=1 SHALL clear busy[writePort] at the end of that cycle.
REQ-024 Set and clear of the same index in the same cycle: set SHALL win.
REQ-025 hazard SHALL be 1 iff (rs1!=0 and busy[rs1]) or (rs2!=0 and busy[rs2]), excluding an index equal to writePort while regWrite=1 (value is being written that cycle).
REQ-026 Requests arriving while busy[rd] is already 0 SHALL still be written normally (no scoreboard checking on writeback).

Reset
REQ-027 With rst=1 at a rising edge: regWrite=0, writePort=0, busC=0, busy all 0, last_grant=ALU (mem wins first conflict), next cycle.
REQ-028 While rst=1: alu_ready=0, mem_ready=0, hazard=0; issue_valid ignored.
REQ-029 Reset mid-operation SHALL drop any writeback registered in the reset cycle; no write reaches the bank after reset asserts.

Verification
REQ-030 Single ALU: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 cycle N; regWrite=1, writePort=5, busC=0xDEADBEEF cycle N+1 only.
REQ-031 Conflict FIXED_PRIO=0 from reset: both valid, rd 3/4 held -> mem(4) granted cycle N, alu(3) N+1; writes 4 then 3 back-to-back.
REQ-032 Conflict FIXED_PRIO=1: mem_valid held 3 cycles with alu_valid -> alu_ready 0 throughout, granted first cycle mem_valid drops.
REQ-033 Scoreboard: issue rd=7; rs1=7 -> hazard=1; ALU writes rd=7 -> hazard=0 in regWrite cycle and after; same-cycle reissue of 7 -> hazard=1 afterwards.
REQ-034 rd=0: mem_valid, mem_rd=0 -> mem_ready=1, regWrite stays 0; rs1=0 never raises hazard.
REQ-035 Reset mid-op: transfer in cycle N, rst=1 in N+1 -> regWrite=0 in N+1, busy cleared, hazard=0.
